// File: rtl/jtsdram_prog.sv
`default_nettype none
// ============================================================================
// Module   : jtsdram_prog
// Purpose  : Writes a seed-derived data pattern to every word of all four
//            SDRAM banks through the controller programming port, then
//            raises prog_done (with prog_err if a write was never acked).
// Revision : 1.0 - initial release
// ============================================================================
module jtsdram_prog #(
    parameter int AW   = 22,
    parameter int GAP  = 0,
    parameter int TOUT = 255
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          prog_start,
    input  logic [15:0]   data_ref,
    output logic          prog_done,
    output logic          prog_err,
    output logic          prog_we,
    output logic [1:0]    prog_ba,
    output logic [AW-1:0] prog_addr,
    output logic [15:0]   prog_data,
    input  logic          prog_ack
);

    // Gap counter runs 0..GAP-1, timeout counter runs 0..TOUT.
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int TW = (TOUT > 1) ? $clog2(TOUT + 1) : 1;
    localparam logic [GW-1:0] c_gap_last  = GW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [TW-1:0] c_tout_last = TW'(TOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     seed_q,  seed_d;
    logic            done_q,  done_d;
    logic            err_q,   err_d;
    logic            we_q,    we_d;
    logic [1:0]      ba_q,    ba_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [15:0]     data_q,  data_d;
    logic [GW-1:0]   gap_q,   gap_d;
    logic [TW-1:0]   tout_q,  tout_d;

    logic [AW+1:0]   w_next_pos;
    logic            w_last;
    logic [15:0]     w_addr16;

    // Pattern uses the low 16 address bits, zero-extended for narrow banks.
    generate
        if (AW >= 16) begin : g_addr_trunc
            assign w_addr16 = addr_d[15:0];
        end else begin : g_addr_zext
            assign w_addr16 = {{(16 - AW){1'b0}}, addr_d};
        end
    endgenerate

    // Bank and address form one bank-major counter; carry out of addr bumps bank.
    assign w_next_pos = {ba_q, addr_q} + (AW + 2)'(1);
    assign w_last     = (ba_q == 2'd3) && (&addr_q);

    // Next-state logic; data follows the next position so it moves with addr/ba.
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        done_d  = done_q;
        err_d   = err_q;
        we_d    = we_q;
        ba_d    = ba_q;
        addr_d  = addr_q;
        gap_d   = gap_q;
        tout_d  = tout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (prog_start) begin
                    seed_d  = data_ref;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    ba_d    = 2'd0;
                    addr_d  = '0;
                    we_d    = 1'b1;
                    gap_d   = '0;
                    tout_d  = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (we_q && prog_ack) begin
                    tout_d = '0;
                    if (w_last) begin
                        we_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        {ba_d, addr_d} = w_next_pos;
                        if (GAP > 0) begin
                            we_d    = 1'b0;
                            gap_d   = '0;
                            state_d = S_GAP;
                        end
                    end
                end else if (we_q) begin
                    // Stalled word: abort once TOUT unacked cycles have elapsed,
                    // leaving ba/addr on the failing word.
                    tout_d = tout_q + TW'(1);
                    if (tout_q == c_tout_last) begin
                        we_d    = 1'b0;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == c_gap_last) begin
                    we_d    = 1'b1;
                    tout_d  = '0;
                    state_d = S_WRITE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        data_d = seed_d ^ w_addr16 ^ {ba_d, 14'd0};
    end

    // State and output registers, cleared asynchronously so a reset abandons the pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            seed_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            ba_q    <= 2'd0;
            addr_q  <= '0;
            data_q  <= '0;
            gap_q   <= '0;
            tout_q  <= '0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
            tout_q  <= tout_d;
        end
    end

    assign prog_done = done_q;
    assign prog_err  = err_q;
    assign prog_we   = we_q;
    assign prog_ba   = ba_q;
    assign prog_addr = addr_q;
    assign prog_data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_jtsdram_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtsdram_prog
// Purpose  : Self-checking bench for jtsdram_prog (AW=4) with random ack
//            stalls, mid-pass start/seed noise, timeout and reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtsdram_prog;

    logic        clk = 1'b0;
    logic        rst;

    logic        start_a, ack_a, done_a, err_a, we_a;
    logic [15:0] dref_a, data_a;
    logic [1:0]  ba_a;
    logic [3:0]  addr_a;

    logic        start_b, ack_b, done_b, err_b, we_b;
    logic [15:0] dref_b, data_b;
    logic [1:0]  ba_b;
    logic [3:0]  addr_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jtsdram_prog #(.AW(4), .GAP(0), .TOUT(8)) u_dut_a (
        .rst(rst), .clk(clk), .prog_start(start_a), .data_ref(dref_a),
        .prog_done(done_a), .prog_err(err_a), .prog_we(we_a), .prog_ba(ba_a),
        .prog_addr(addr_a), .prog_data(data_a), .prog_ack(ack_a)
    );

    jtsdram_prog #(.AW(4), .GAP(2), .TOUT(8)) u_dut_b (
        .rst(rst), .clk(clk), .prog_start(start_b), .data_ref(dref_b),
        .prog_done(done_b), .prog_err(err_b), .prog_we(we_b), .prog_ba(ba_b),
        .prog_addr(addr_b), .prog_data(data_b), .prog_ack(ack_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: word k of a pass is bank k/16, address k%16.
    function automatic logic [21:0] word_of(input logic [15:0] seed, input int k);
        int ba;
        int ad;
        logic [15:0] d;
        ba = k / 16;
        ad = k % 16;
        d  = seed ^ 16'(ad) ^ 16'(ba << 14);
        return {2'(ba), 4'(ad), d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] seed);
        dref_a  = seed;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("start_done", 32'(done_a), 32'd0);
        chk("start_err", 32'(err_a), 32'd0);
        chk("start_word", 32'({we_a, ba_a, addr_a, data_a}), 32'({1'b1, word_of(seed, 0)}));
    endtask

    task automatic run_pass(input logic [15:0] seed, input int max_stall, input bit noise,
                            output int ncyc);
        int k;
        int stall;
        int guard;
        k     = 0;
        guard = 0;
        ncyc  = 0;
        stall = $urandom_range(max_stall, 0);
        while (!done_a && guard < 3000) begin
            guard++;
            ncyc++;
            chk("we_hi", 32'(we_a), 32'd1);
            chk("word", 32'({ba_a, addr_a, data_a}), 32'(word_of(seed, k)));
            if (noise) begin
                dref_a  = 16'($urandom);
                start_a = ($urandom_range(7, 0) == 0);
            end
            if (stall > 0) begin
                ack_a = 1'b0;
                stall--;
            end else begin
                ack_a = 1'b1;
                k++;
                stall = $urandom_range(max_stall, 0);
            end
            tick();
        end
        start_a = 1'b0;
        ack_a   = 1'b0;
        chk("pass_done", 32'(done_a), 32'd1);
        chk("pass_words", 32'(k), 32'd64);
        chk("pass_err", 32'(err_a), 32'd0);
        chk("pass_we", 32'(we_a), 32'd0);
    endtask

    initial begin
        int n;
        logic [15:0] s, s2, base;

        rst = 1'b1;
        start_a = 1'b0; ack_a = 1'b0; dref_a = '0;
        start_b = 1'b0; ack_b = 1'b1; dref_b = '0;
        tick();
        tick();
        chk("reset_outs", 32'({done_a, err_a, we_a, ba_a, addr_a, data_a}), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_outs", 32'({done_a, err_a, we_a}), 32'd0);

        // Back-to-back pass, ack tied high.
        ack_a = 1'b1;
        do_start(16'hAAAA);
        run_pass(16'hAAAA, 0, 1'b0, n);
        chk("b2b_cycles", 32'(n), 32'd64);
        tick(); tick(); tick();
        chk("done_held", 32'({done_a, err_a}), 32'b10);

        // GAP=2 instance: we pattern 1,0,0 and pass length.
        dref_b  = 16'h1234;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 1000) begin
            chk("gap_we", 32'(we_b), 32'(n % 3 == 0));
            if (we_b)
                chk("gap_word", 32'({ba_b, addr_b, data_b}), 32'(word_of(16'h1234, n / 3)));
            n++;
            tick();
        end
        chk("gap_cycles", 32'(n), 32'd190);
        chk("gap_flags", 32'({done_b, err_b, we_b}), 32'b100);

        // Random stalls below the timeout.
        s = 16'($urandom);
        do_start(s);
        run_pass(s, 5, 1'b0, n);

        // Mid-pass start pulses and data_ref changes must be ignored.
        s = 16'($urandom);
        do_start(s);
        run_pass(s, 2, 1'b1, n);

        // Timeout on bank 2 address 3.
        s = 16'($urandom);
        do_start(s);
        ack_a = 1'b1;
        for (int k = 0; k < 35; k++) tick();
        chk("to_word", 32'({we_a, ba_a, addr_a, data_a}), 32'({1'b1, word_of(s, 35)}));
        ack_a = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i < 8) chk("to_pending", 32'({done_a, err_a, we_a}), 32'b001);
        end
        chk("to_flags", 32'({done_a, err_a, we_a}), 32'b110);
        chk("to_frozen", 32'({ba_a, addr_a, data_a}), 32'(word_of(s, 35)));
        tick(); tick();
        chk("to_frozen2", 32'({done_a, err_a, we_a, ba_a, addr_a}), 32'({3'b110, 2'd2, 4'd3}));
        s2 = 16'($urandom);
        do_start(s2);
        run_pass(s2, 1, 1'b0, n);

        // Asynchronous reset mid-pass.
        s = 16'($urandom);
        do_start(s);
        ack_a = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1;
        #1;
        chk("arst_outs", 32'({done_a, err_a, we_a, ba_a, addr_a, data_a}), 32'd0);
        tick();
        rst   = 1'b0;
        ack_a = 1'b0;
        tick();
        chk("arst_idle", 32'({done_a, err_a, we_a}), 32'd0);
        s = 16'($urandom);
        do_start(s);
        run_pass(s, 3, 1'b0, n);

        // Sequencer-style loop of three passes with incrementing seed.
        base = 16'($urandom);
        for (int p = 0; p < 3; p++) begin
            do_start(base + 16'(p));
            run_pass(base + 16'(p), 3, 1'b1, n);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtsdram_prog.md
# jtsdram_prog

Pattern programmer on the responder side of the test sequencer's `prog_start`/`prog_done` handshake. On a start pulse it latches `data_ref` and writes a deterministic data pattern to every word of all four SDRAM banks through the controller's programming port. When the pass completes it raises `prog_done`. The bank readers then check the same pattern, recomputed from the same `data_ref`.

## Interface
Parameters:
- `AW`, default 22: word address width per bank.
- `GAP`, default 0: idle cycles inserted after each accepted write (0 = back-to-back).
- `TOUT`, default 255: maximum cycles `prog_we` may wait for `prog_ack` before the pass aborts. Must be ≥1.

Ports:
- `rst` input 1: reset, asynchronous, active-high.
- `clk` input 1: clock.
- `prog_start` input 1: start request. Sampled every cycle.
- `data_ref` input 16: pattern seed. Latched on an accepted start.
- `prog_done` output 1: pass finished, normally or aborted. Held until the next accepted start.
- `prog_err` output 1: pass aborted on timeout. Sticky until the next accepted start.
- `prog_we` output 1: write request to the SDRAM controller.
- `prog_ba` output 2: bank of the current write.
- `prog_addr` output AW: word address of the current write.
- `prog_data` output 16: data of the current write.
- `prog_ack` input 1: controller accepted the write this cycle. Ignored while `prog_we`=0.

## Operation
- States: IDLE, WRITE, GAP, DONE.
- Reset values: state IDLE; `prog_done`=0, `prog_err`=0, `prog_we`=0, `prog_ba`=0, `prog_addr`=0, `prog_data`=0; seed register 0; gap and timeout counters 0.
- IDLE/DONE with `prog_start`=1 (accepted start):
  - latch `data_ref` into the seed register;
  - clear `prog_done` and `prog_err`;
  - set `prog_ba`=0, `prog_addr`=0, `prog_we`=1;
  - go to WRITE.
- `prog_start` is ignored in WRITE and GAP. A pass always runs to completion or timeout.
- Pattern: `prog_data` = seed ^ zext16(`prog_addr`) ^ {`prog_ba`, 14'd0}.
  - If AW>16, only `prog_addr[15:0]` is used.
  - `prog_data` is registered and changes only together with `prog_addr`/`prog_ba`.
- Sequence is bank-major: bank 0 addresses 0 … 2^AW−1, then bank 1, bank 2, bank 3.
- WRITE, on `prog_ack`=1 (write accepted):
  - Last word (`prog_ba`=3 and `prog_addr` all ones): `prog_we`←0, `prog_done`←1, go to DONE.
  - Otherwise `prog_addr`←`prog_addr`+1. On address wrap to 0, `prog_ba`←`prog_ba`+1.
  - Then: if GAP=0, stay in WRITE with `prog_we`=1; if GAP>0, `prog_we`←0 and go to GAP.
- GAP: count GAP cycles with `prog_we`=0, then `prog_we`←1 and return to WRITE.
- WRITE timeout:
  - The timeout counter increments each cycle `prog_we`=1 and `prog_ack`=0, and clears on ack or on entering WRITE.
  - When it reaches TOUT without ack: `prog_we`←0, `prog_err`←1, `prog_done`←1, go to DONE.
  - `prog_ba`/`prog_addr` freeze at the failing word for debug.
- `prog_we`, `prog_ba`, `prog_addr` and `prog_data` stay stable while `prog_we`=1 and no ack has been received.
- Reset asserted mid-pass: all outputs return to reset values immediately (asynchronous) and the pass is abandoned. No partial completion is flagged.

## Timing
- Accepted start at edge N:
  - `prog_done`=0 and `prog_we`=1, addr 0, bank 0 after edge N.
  - A sequencer that drops `prog_start` after one cycle and waits for `prog_done` therefore never samples a stale done.
- Write acceptance: `prog_ack`=1 while `prog_we`=1 at edge M. The next word is presented after edge M (GAP=0), or `prog_we` drops for GAP cycles first.
- Back-to-back pass with `prog_ack` tied high and GAP=0: exactly 4·2^AW cycles with `prog_we`=1. `prog_done` rises on the edge that accepts the last word.
- General pass length (ack tied high): 4·2^AW·(1+GAP) − GAP cycles from the first `prog_we` to `prog_done`.
- Timeout: `prog_err` and `prog_done` rise TOUT cycles after the stalled word was first presented.
- Start on the same edge as `prog_done` rises: not accepted; it is sampled only from the next cycle in DONE.

## Test plan
- AW=4, GAP=0, ack tied 1, `data_ref`=16'hAAAA, 1-cycle start:
  - expect 64 writes, bank 0..3 × addr 0..15;
  - bank 1 addr 5 data = 16'hAAAA^16'h0005^16'h4000 = 16'hEAAF;
  - `prog_done` high after the 64th write; `prog_err`=0.
- AW=4, GAP=2, ack tied 1: `prog_we` pattern 1,0,0 repeating; `prog_done` 190 cycles after the first `prog_we`.
- Random ack stalls of 0–5 cycles with TOUT=8:
  - address/data stable during each stall;
  - all 64 words written exactly once, in order;
  - no error.
- Ack held 0 from bank 2 addr 3, TOUT=8:
  - `prog_err`=1 and `prog_done`=1 eight cycles after that word appears;
  - `prog_ba`=2, `prog_addr`=3 frozen.
  - A new start clears both flags and restarts at bank 0 addr 0 with the new seed.
- `prog_start` pulsed mid-pass: ignored, with no address reset and no seed change. Reset asserted mid-pass: all outputs 0 in the same cycle; a start after reset release runs a full pass.
- Loop with a sequencer-style driver: start, wait done, `data_ref`+1, restart for 3 passes. Check that each pass's data uses its own latched seed, even when `data_ref` changes mid-pass.
